// File: rtl/range_calc_seq.sv
// Sequential projectile-range engine: R = vx*(vy + sqrt(vy^2 + 2*g*h))/g via bit-serial sqrt and divide.
// Define RANGE_TOF_EN to add a TDIV pass that reuses the divider for time of flight (tof_ms port).
module range_calc_seq #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int G_MMPS2 = 9800
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [W-1:0]    speed,
    input  logic [W-1:0]    init,
    input  logic [FRAC:0]   cos_q,
    input  logic [FRAC:0]   sin_q,
    output logic            rdy,
    output logic            done,
    output logic [W-1:0]    range,
    output logic            ovf
`ifdef RANGE_TOF_EN
    ,
    output logic [W-1:0]    tof_ms
`endif
);

    generate
        if (G_MMPS2 <= 0) begin : g_bad_gravity
            $error("range_calc_seq: G_MMPS2 must be > 0");
        end
    endgenerate

    localparam int RADW = 2*W + 2;              // radical / dividend width
    localparam int RW   = W + 2;                // sqrt partial remainder width
    localparam int PW   = W + FRAC + 1;         // speed * trig product width
    localparam int GW   = $clog2(G_MMPS2) + 2;  // divider remainder, holds up to 2*G
    localparam int CW   = $clog2(RADW + 1);

    localparam logic [FRAC:0]   ONE  = {1'b1, {FRAC{1'b0}}};
    localparam logic [GW-1:0]   GDIV = GW'(G_MMPS2);
    localparam logic [RADW-1:0] G2   = RADW'(2 * G_MMPS2);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_SQRT, S_MULT, S_DIV, S_TDIV, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      sp_q, sp_d, ini_q, ini_d;
    logic [FRAC:0]     cosl_q, cosl_d, sinl_q, sinl_d;
    logic [W-1:0]      vx_q, vx_d, vy_q, vy_d;
    logic [RADW-1:0]   rad_q, rad_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [W:0]        root_q, root_d;
    logic [RADW-1:0]   dvd_q, dvd_d;
    logic [GW-1:0]     drm_q, drm_d;
    logic [W-1:0]      range_q, range_d;
    logic              ovf_q, ovf_d;
`ifdef RANGE_TOF_EN
    logic [RW-1:0]     vs_q, vs_d;
    logic [W-1:0]      rres_q, rres_d;
    logic              rovf_q, rovf_d;
    logic [W-1:0]      tof_q, tof_d;
`endif

    // single-step datapath terms, shared by the states that iterate
    logic [W+3:0]      sq_rem;
    logic [W+2:0]      sq_trial;
    logic              sq_ge;
    logic [GW:0]       dv_rem;
    logic              dv_bit;
    logic [RADW-1:0]   quot;
    logic              qsat;
    logic [W-1:0]      qres;
    logic [W-1:0]      vy_c;

    always_comb begin
        sq_rem   = {rem_q, rad_q[RADW-1 -: 2]};
        sq_trial = {root_q, 2'b01};
        sq_ge    = sq_rem >= {1'b0, sq_trial};
        dv_rem   = {drm_q, dvd_q[RADW-1]};
        dv_bit   = dv_rem >= {1'b0, GDIV};
        quot     = {dvd_q[RADW-2:0], dv_bit};
        qsat     = |quot[RADW-1:W];
        qres     = qsat ? '1 : quot[W-1:0];
        vy_c     = W'((PW'(sp_q) * PW'(sinl_q)) >> FRAC);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        ini_d   = ini_q;
        cosl_d  = cosl_q;
        sinl_d  = sinl_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        dvd_d   = dvd_q;
        drm_d   = drm_q;
        range_d = range_q;
        ovf_d   = ovf_q;
`ifdef RANGE_TOF_EN
        vs_d    = vs_q;
        rres_d  = rres_q;
        rovf_d  = rovf_q;
        tof_d   = tof_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sp_d    = speed;
                    ini_d   = init;
                    cosl_d  = (cos_q > ONE) ? ONE : cos_q;
                    sinl_d  = (sin_q > ONE) ? ONE : sin_q;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                vx_d    = W'((PW'(sp_q) * PW'(cosl_q)) >> FRAC);
                vy_d    = vy_c;
                rad_d   = RADW'(vy_c) * RADW'(vy_c) + G2 * RADW'(ini_q);
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rad_d  = {rad_q[RADW-3:0], 2'b00};
                rem_d  = sq_ge ? RW'(sq_rem - {1'b0, sq_trial}) : RW'(sq_rem);
                root_d = {root_q[W-1:0], sq_ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W))
                    state_d = S_MULT;
            end
            S_MULT: begin
                dvd_d   = RADW'(vx_q) * (RADW'(vy_q) + RADW'(root_q));
`ifdef RANGE_TOF_EN
                vs_d    = RW'(vy_q) + RW'(root_q);
`endif
                drm_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                dvd_d = quot;
                drm_d = dv_bit ? GW'(dv_rem - {1'b0, GDIV}) : GW'(dv_rem);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RADW - 1)) begin
`ifdef RANGE_TOF_EN
                    // park the range result; outputs only move together at DONE
                    rres_d  = qres;
                    rovf_d  = qsat;
                    dvd_d   = RADW'(vs_q) * RADW'(1000);
                    drm_d   = '0;
                    cnt_d   = '0;
                    state_d = S_TDIV;
`else
                    range_d = qres;
                    ovf_d   = qsat;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef RANGE_TOF_EN
            S_TDIV: begin
                dvd_d = quot;
                drm_d = dv_bit ? GW'(dv_rem - {1'b0, GDIV}) : GW'(dv_rem);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RADW - 1)) begin
                    tof_d   = qres;
                    range_d = rres_q;
                    ovf_d   = rovf_q;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sp_q    <= '0;
            ini_q   <= '0;
            cosl_q  <= '0;
            sinl_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            dvd_q   <= '0;
            drm_q   <= '0;
            range_q <= '0;
            ovf_q   <= 1'b0;
`ifdef RANGE_TOF_EN
            vs_q    <= '0;
            rres_q  <= '0;
            rovf_q  <= 1'b0;
            tof_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            ini_q   <= ini_d;
            cosl_q  <= cosl_d;
            sinl_q  <= sinl_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            dvd_q   <= dvd_d;
            drm_q   <= drm_d;
            range_q <= range_d;
            ovf_q   <= ovf_d;
`ifdef RANGE_TOF_EN
            vs_q    <= vs_d;
            rres_q  <= rres_d;
            rovf_q  <= rovf_d;
            tof_q   <= tof_d;
`endif
        end
    end

    assign rdy   = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign range = range_q;
    assign ovf   = ovf_q;
`ifdef RANGE_TOF_EN
    assign tof_ms = tof_q;
`endif

endmodule

// File: tb/tb_range_calc_seq.sv
// Directed self-checking bench for range_calc_seq (W=32, FRAC=16, G=9800); honours RANGE_TOF_EN.
module tb_range_calc_seq;

`ifdef RANGE_TOF_EN
    localparam int LAT = 5*32 + 8;
`else
    localparam int LAT = 3*32 + 6;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] speed = '0;
    logic [31:0] init = '0;
    logic [16:0] cos_q = '0;
    logic [16:0] sin_q = '0;
    logic        rdy, done, ovf;
    logic [31:0] range;
`ifdef RANGE_TOF_EN
    logic [31:0] tof_ms;
`endif

    int total = 0;
    int bad   = 0;

    range_calc_seq #(.W(32), .FRAC(16), .G_MMPS2(9800)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .speed(speed), .init(init),
        .cos_q(cos_q), .sin_q(sin_q), .rdy(rdy), .done(done), .range(range), .ovf(ovf)
`ifdef RANGE_TOF_EN
        , .tof_ms(tof_ms)
`endif
    );

    always #5 clk = ~clk;

    // one request; lat = cycle index of done (accept cycle is 0), -1 on timeout
    task automatic do_req(input logic [31:0] sp, input logic [31:0] ih,
                          input logic [16:0] c, input logic [16:0] s,
                          output int lat, output logic held);
        logic [31:0] r0;
        @(negedge clk);
        speed = sp; init = ih; cos_q = c; sin_q = s; start = 1'b1;
        r0 = range; held = 1'b1; lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (range !== r0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rdy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL reset_hs got rdy=%b done=%b want 1/0", rdy, done); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (range !== 32'd0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_out got range=%0d ovf=%b want 0/0", range, ovf); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got %b want 1", rdy); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd0) begin bad++; $display("FAIL reset_tof got %0d want 0", tof_ms); end
`endif
    endtask

    task automatic test_basic();
        int lat; logic held;
        do_req(32'd20000, 32'd0, 17'd32768, 17'd32768, lat, held);
        total++; if (lat !== LAT) begin bad++; $display("FAIL basic_lat got %0d want %0d", lat, LAT); end
        total++; if (range !== 32'd20408 || ovf !== 1'b0) begin bad++; $display("FAIL basic_range got %0d ovf=%b want 20408/0", range, ovf); end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL basic_hold range moved before done"); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd2040) begin bad++; $display("FAIL basic_tof got %0d want 2040", tof_ms); end
`endif
        @(negedge clk);
        total++; if (done !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL basic_pulse got done=%b rdy=%b want 0/1", done, rdy); end
    endtask

    task automatic test_init_height();
        int lat; logic held;
        do_req(32'd20000, 32'd1000, 17'd32768, 17'd32768, lat, held);
        total++; if (lat !== LAT) begin bad++; $display("FAIL height_lat got %0d want %0d", lat, LAT); end
        total++; if (range !== 32'd21363 || ovf !== 1'b0) begin bad++; $display("FAIL height_range got %0d ovf=%b want 21363/0", range, ovf); end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL height_hold range moved before done"); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd2136) begin bad++; $display("FAIL height_tof got %0d want 2136", tof_ms); end
`endif
    endtask

    task automatic test_abort();
        int seen = 0;
        @(negedge clk);
        speed = 32'd20000; init = 32'd0; cos_q = 17'd32768; sin_q = 17'd32768; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);  // cycle 60: inside DIV
        reset_n = 1'b0;
        #1;
        total++; if (rdy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort_hs got rdy=%b done=%b want 1/0", rdy, done); end
        total++; if (range !== 32'd0 || ovf !== 1'b0) begin bad++; $display("FAIL abort_out got range=%0d ovf=%b want 0/0", range, ovf); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 250; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_nodone got %0d done pulses want 0", seen); end
    endtask

    task automatic test_zero();
        int lat; logic held;
        do_req(32'd0, 32'd5000, 17'd32768, 17'd32768, lat, held);
        total++; if (lat !== LAT) begin bad++; $display("FAIL zero_lat got %0d want %0d", lat, LAT); end
        total++; if (range !== 32'd0 || ovf !== 1'b0) begin bad++; $display("FAIL zero_range got %0d ovf=%b want 0/0", range, ovf); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd1010) begin bad++; $display("FAIL zero_tof got %0d want 1010", tof_ms); end
`endif
        do_req(32'd10000, 32'd0, 17'd65536, 17'd0, lat, held);
        total++; if (range !== 32'd0 || ovf !== 1'b0) begin bad++; $display("FAIL flat_range got %0d ovf=%b want 0/0", range, ovf); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd0) begin bad++; $display("FAIL flat_tof got %0d want 0", tof_ms); end
`endif
    endtask

    task automatic test_saturate();
        int lat; logic held;
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 17'd65536, 17'd65536, lat, held);
        total++; if (lat !== LAT) begin bad++; $display("FAIL sat_lat got %0d want %0d", lat, LAT); end
        total++; if (range !== 32'hFFFF_FFFF || ovf !== 1'b1) begin bad++; $display("FAIL sat_range got %h ovf=%b want ffffffff/1", range, ovf); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd876524937) begin bad++; $display("FAIL sat_tof got %0d want 876524937", tof_ms); end
`endif
    endtask

    task automatic test_clamp();
        int lat; logic held;
        // out-of-range trig clamps to 1.0: vx=vy=20000
        do_req(32'd20000, 32'd0, 17'h1FFFF, 17'h1FFFF, lat, held);
        total++; if (range !== 32'd81632 || ovf !== 1'b0) begin bad++; $display("FAIL clamp_range got %0d ovf=%b want 81632/0", range, ovf); end
`ifdef RANGE_TOF_EN
        total++; if (tof_ms !== 32'd4081) begin bad++; $display("FAIL clamp_tof got %0d want 4081", tof_ms); end
`endif
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, pulses = 0;
        logic [31:0] r1 = '0, r2 = '0;
        @(negedge clk);
        speed = 32'd20000; init = 32'd0; cos_q = 17'd32768; sin_q = 17'd32768; start = 1'b1;
        for (int n = 1; n <= 2*LAT + 20; n++) begin
            @(negedge clk);
            if (n == 50) init = 32'd1000;  // must not touch the request in flight
            if (done) begin
                pulses++;
                if (first < 0) begin first = n; r1 = range; end
                else begin second = n; r2 = range; start = 1'b0; break; end
            end
        end
        start = 1'b0;
        total++; if (first !== LAT) begin bad++; $display("FAIL b2b_first got %0d want %0d", first, LAT); end
        total++; if (second !== 2*LAT + 1) begin bad++; $display("FAIL b2b_second got %0d want %0d", second, 2*LAT + 1); end
        total++; if (r1 !== 32'd20408) begin bad++; $display("FAIL b2b_r1 got %0d want 20408", r1); end
        total++; if (r2 !== 32'd21363) begin bad++; $display("FAIL b2b_r2 got %0d want 21363", r2); end
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        repeat (3) @(negedge clk);
        total++; if (rdy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_idle got rdy=%b done=%b want 1/0", rdy, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_init_height();
        test_abort();
        test_zero();
        test_saturate();
        test_clamp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
